// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice is summed per stage, with
// operands skewed forward and the ripple carry registered between stages.
module pipe_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    // WIDTH must be a multiple of STAGES so every stage owns an equal slice.
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [WIDTH-1:0] opA_q   [STAGES];
    logic [WIDTH-1:0] opB_q   [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] opA_d   [STAGES];
    logic [WIDTH-1:0] opB_d   [STAGES];
    logic [WIDTH-1:0] res_d   [STAGES];
    logic [WIDTH-1:0] resIn   [STAGES];
    logic             carry_d [STAGES];
    logic             valid_d [STAGES];
    logic             stageCin[STAGES];
    logic [CHUNK:0]   chunkSum[STAGES];
    logic             ovf_d;
    logic             zero_d;
    logic             stall;

    assign stall    = valid_q[LAST] && !out_ready;
    assign in_ready = !stall && !rst;

    // Stage 0 sees the raw operands (B already inverted for subtract); every later
    // stage sees the previous stage's registers and adds only its own slice.
    always_comb begin
        opA_d[0]    = a;
        opB_d[0]    = sub ? ~b : b;
        stageCin[0] = sub | c_in;
        resIn[0]    = '0;
        valid_d[0]  = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            opA_d[k]    = opA_q[k-1];
            opB_d[k]    = opB_q[k-1];
            stageCin[k] = carry_q[k-1];
            resIn[k]    = res_q[k-1];
            valid_d[k]  = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunkSum[k] = {1'b0, opA_d[k][k*CHUNK +: CHUNK]}
                        + {1'b0, opB_d[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, stageCin[k]};
            res_d[k]    = resIn[k];
            res_d[k][k*CHUNK +: CHUNK] = chunkSum[k][CHUNK-1:0];
            carry_d[k]  = chunkSum[k][CHUNK];
        end
        ovf_d  = (opA_d[LAST][WIDTH-1] == opB_d[LAST][WIDTH-1]) &&
                 (res_d[LAST][WIDTH-1] != opA_d[LAST][WIDTH-1]);
        zero_d = (res_d[LAST] == '0);
    end

    // The whole pipe advances together or freezes together on a downstream stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k]   <= '0;
                opB_q[k]   <= '0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k]   <= opA_d[k];
                opB_q[k]   <= opB_d[k];
                res_q[k]   <= res_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            ovf_q  <= valid_d[LAST] && ovf_d;
            zero_q <= valid_d[LAST] && zero_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = res_q[LAST];
    assign c_out     = carry_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH % STAGES == 0 is required, and CHUNK = WIDTH/STAGES bits are summed per stage.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: operand beat can be accepted this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port sub, input, 1 bit: 0 selects A+B+c_in; 1 selects A-B.
REQ-010 SHALL have port c_in, input, 1 bit: carry-in, used only when sub=0.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result beat.
REQ-013 SHALL have port sum, output, WIDTH bits: result.
REQ-014 SHALL have port c_out, output, 1 bit: carry out of the MSB; for sub, 1 means no borrow.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-016 SHALL have port zero, output, 1 bit: sum equals 0.

Function
REQ-017 SHALL accept a beat when in_valid && in_ready, capturing a, b, sub and c_in on that edge.
REQ-018 SHALL compute A + ~B + 1 when sub=1 (c_in ignored), and A + B + c_in when sub=0.
REQ-019 SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) in stage k, using the registered carry from stage k-1; stage 0 uses the effective carry-in.
REQ-020 SHALL skew operand chunks so that chunk k is added exactly k cycles after acceptance, with lower result chunks delayed to align.
REQ-021 SHALL assert out_valid exactly STAGES cycles after acceptance when no stall occurs (latency = STAGES).
REQ-022 SHALL sustain one accepted beat per cycle when out_ready is held at 1.
REQ-023 SHALL define stall = out_valid && !out_ready; on stall, every pipeline register, valid bit and output holds its value.
REQ-024 SHALL drive in_ready = !stall && !rst (combinational).
REQ-025 SHALL hold sum, c_out, ovf and zero stable while out_valid=1 and out_ready=0.
REQ-026 SHALL compute ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective (possibly inverted) B.
REQ-027 SHALL compute zero from the full aligned WIDTH-bit sum in the final stage.
REQ-028 SHALL let bubbles (in_valid=0) propagate as invalid slots without affecting neighbouring beats.
REQ-029 SHALL wrap arithmetic modulo 2^WIDTH, with the lost MSB carry reported only on c_out.
REQ-030 SHALL deliver beats in acceptance order, with no loss or duplication across any stall pattern.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, clear every valid bit and data register to 0, giving out_valid=0, sum=0, c_out=0, ovf=0 and zero=0.
REQ-032 SHALL hold in_ready=0 while rst=1; beats in flight are discarded and produce no output after reset.
REQ-033 SHALL be able to accept a beat on the first edge after rst deasserts.

Verification (WIDTH=64, STAGES=4)
REQ-034 SHALL pass the carry-ripple case: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, c_in=0 -> 4 cycles later sum=0, c_out=1, zero=1, ovf=0.
REQ-035 SHALL pass the signed-overflow case: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, c_out=0.
REQ-036 SHALL pass the subtract/borrow cases: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0; a=7, b=7, sub=1, c_in=1 -> sum=0, c_out=1, zero=1.
REQ-037 SHALL pass back-to-back streaming: 1000 random beats (a, b, sub, c_in) at full rate with out_ready=1 -> results in order, each matching a 65-bit golden model, one per cycle after 4-cycle fill.
REQ-038 SHALL pass the backpressure case: random out_ready (50%) with in_valid=1 -> in_ready low exactly when stalled, outputs stable while stalled, and no beat lost or duplicated.
REQ-039 SHALL pass reset mid-stream: 3 beats in flight, then rst for 1 cycle -> out_valid stays 0 until a new beat is accepted, and that beat emerges 4 cycles later.
